// File: rtl/instruction_memory_loader.sv
// Streams little-endian bytes into XLEN-bit words and writes them to consecutive
// instruction memory addresses from 0, holding the core in reset until the image is complete.
module instruction_memory_loader #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [XLEN-1:0]       mem_write_data,
  output logic                  cpu_hold,
  output logic                  done
);

  localparam int BYTES = XLEN / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t              state, state_next;
  logic [IDX_W-1:0]    byte_idx;
  logic [ADDR_WIDTH:0] word_cnt, word_cnt_inc, target, target_next;
  logic                start_ok, byte_fire, last_byte, last_word;

  assign start_ok     = start && ((state == IDLE) || (state == DONE));
  assign target_next  = (num_words > DEPTH_CNT) ? DEPTH_CNT : num_words;
  assign word_cnt_inc = word_cnt + CNT_ONE;
  assign byte_fire    = byte_valid && byte_ready;
  assign last_byte    = (byte_idx == LAST_IDX);
  assign last_word    = (word_cnt_inc == target);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    byte_ready       = 1'b0;
    mem_write_enable = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = (target_next == '0) ? DONE : LOAD;
      end
      LOAD: begin
        byte_ready = 1'b1;
        if (byte_valid && last_byte) state_next = WRITE;
      end
      WRITE: begin
        mem_write_enable = 1'b1;
        state_next       = last_word ? DONE : LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // done/cpu_hold are registered so a zero-length load still shows one cycle of hold
  always_ff @(posedge clock) begin
    if (reset) begin
      target            <= '0;
      word_cnt          <= '0;
      byte_idx          <= '0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      cpu_hold          <= 1'b0;
      done              <= 1'b0;
    end else if (start_ok) begin
      target            <= target_next;
      word_cnt          <= '0;
      byte_idx          <= '0;
      mem_write_address <= '0;
      cpu_hold          <= 1'b1;
      done              <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (byte_fire) begin
            mem_write_data[{byte_idx, 3'b000} +: 8] <= byte_in;
            byte_idx <= last_byte ? '0 : byte_idx + IDX_W'(1);
          end
        end
        WRITE: begin
          word_cnt <= word_cnt_inc;
          if (last_word) begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            mem_write_address <= mem_write_address + ADDR_WIDTH'(1);
          end
        end
        DONE: begin
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Randomized bench for instruction_memory_loader: a byte-stream driver plus a write/accept
// monitor, checked against words rebuilt from the bench's own byte stream.
module tb_instruction_memory_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  num_words = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, mem_write_enable, cpu_hold, done;
  logic [4:0]  mem_write_address;
  logic [31:0] mem_write_data;

  int total = 0;
  int bad = 0;

  instruction_memory_loader dut (
    .clock(clock), .reset(reset), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .cpu_hold(cpu_hold), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [7:0]  stream [0:255];
  int          cyc = 0;
  int          hold_cnt, done_cyc, rdy_in_wr;
  int          acc_cyc_q[$];
  int          wr_cyc_q[$];
  logic [4:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always @(posedge clock) begin
    if (byte_valid && byte_ready) acc_cyc_q.push_back(cyc);
    if (mem_write_enable) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(mem_write_address);
      wr_data_q.push_back(mem_write_data);
      if (byte_ready) rdy_in_wr = rdy_in_wr + 1;
    end
    if (cpu_hold) hold_cnt = hold_cnt + 1;
    if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    cyc = cyc + 1;
  end

  task automatic clear_mon();
    acc_cyc_q.delete(); wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    hold_cnt = 0; done_cyc = -1; rdy_in_wr = 0;
  endtask

  task automatic fill_stream();
    for (int i = 0; i < 256; i++) stream[i] = 8'($urandom);
  endtask

  // One full load: start, feed stream bytes, then compare against the expected image.
  task automatic do_load(input int n, input int stall_pct, input int gap_after,
                         input int inject, output int cycles);
    int tgt, sent, gap_left, nw;
    bit injected, gapped;
    logic [31:0] exp;
    num_words = 6'(n); start = 1'b1; byte_valid = 1'b0;
    @(posedge clock); #1; start = 1'b0;
    clear_mon();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL start_clears_done n=%0d got=%b want=0", n, done); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL start_sets_hold n=%0d got=%b want=1", n, cpu_hold); end
    tgt = (n < 32) ? n : 32;
    sent = 0; cycles = 0; injected = 0; gapped = 0; gap_left = 0;
    while (done !== 1'b1 && cycles < 3000) begin
      start = 1'b0;
      if (inject >= 0 && !injected && sent == inject && byte_ready === 1'b1) begin
        start = 1'b1; num_words = 6'd1; injected = 1;
      end
      if (gap_after >= 0 && !gapped && sent == gap_after) begin gap_left = 2; gapped = 1; end
      if (gap_left > 0) begin byte_valid = 1'b0; gap_left--; end
      else byte_valid = ($urandom_range(99) >= stall_pct);
      byte_in = stream[sent & 255];
      if (byte_valid && byte_ready) sent++;
      @(posedge clock); #1; cycles++;
    end
    start = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL done_timeout n=%0d got=%b want=1", n, done); end
    byte_valid = 1'b1; byte_in = stream[sent & 255];
    repeat (3) @(posedge clock);
    #1; byte_valid = 1'b0;
    total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL ready_after_done n=%0d got=%b want=0", n, byte_ready); end
    total++; if (wr_addr_q.size() != tgt) begin bad++; $display("FAIL write_count n=%0d got=%0d want=%0d", n, wr_addr_q.size(), tgt); end
    total++; if (acc_cyc_q.size() != 4 * tgt) begin bad++; $display("FAIL accept_count n=%0d got=%0d want=%0d", n, acc_cyc_q.size(), 4 * tgt); end
    total++; if (rdy_in_wr != 0) begin bad++; $display("FAIL ready_in_write n=%0d got=%0d want=0", n, rdy_in_wr); end
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL hold_after_done n=%0d got=%b want=0", n, cpu_hold); end
    nw = (wr_addr_q.size() < tgt) ? wr_addr_q.size() : tgt;
    for (int i = 0; i < nw; i++) begin
      exp = 32'h0;
      for (int k = 0; k < 4; k++) exp = exp | (32'(stream[4 * i + k]) << (8 * k));
      total++; if (wr_addr_q[i] !== 5'(i)) begin bad++; $display("FAIL write_addr n=%0d i=%0d got=%0d want=%0d", n, i, wr_addr_q[i], i); end
      total++; if (wr_data_q[i] !== exp) begin bad++; $display("FAIL write_data n=%0d i=%0d got=%h want=%h", n, i, wr_data_q[i], exp); end
      if (acc_cyc_q.size() > 4 * i + 3) begin
        total++;
        if (wr_cyc_q[i] != acc_cyc_q[4 * i + 3] + 1) begin
          bad++; $display("FAIL write_latency n=%0d i=%0d got=%0d want=%0d", n, i, wr_cyc_q[i], acc_cyc_q[4 * i + 3] + 1);
        end
      end
    end
    if (tgt > 0 && wr_cyc_q.size() > 0) begin
      total++;
      if (done_cyc != wr_cyc_q[wr_cyc_q.size() - 1] + 1) begin
        bad++; $display("FAIL done_latency n=%0d got=%0d want=%0d", n, done_cyc, wr_cyc_q[wr_cyc_q.size() - 1] + 1);
      end
      total++; if (mem_write_address !== 5'(tgt - 1)) begin bad++; $display("FAIL last_addr n=%0d got=%0d want=%0d", n, mem_write_address, tgt - 1); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1; reset = 1'b0;
    total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", byte_ready); end
    total++; if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b want=0", mem_write_enable); end
    total++; if (mem_write_address !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", mem_write_address); end
    total++; if (mem_write_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", mem_write_data); end
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL reset_hold got=%b want=0", cpu_hold); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
  endtask

  task automatic test_single_word();
    int c;
    fill_stream();
    stream[0] = 8'h13; stream[1] = 8'h00; stream[2] = 8'h50; stream[3] = 8'h00;
    do_load(1, 0, -1, -1, c);
    total++; if (wr_data_q.size() < 1 || wr_data_q[0] !== 32'h00500013) begin bad++; $display("FAIL single_word_data got=%h want=00500013", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx); end
    total++; if (c != 5) begin bad++; $display("FAIL single_word_cycles got=%0d want=5", c); end
  endtask

  task automatic test_stall();
    int c;
    fill_stream();
    do_load(3, 0, 5, -1, c);
    total++; if (c != 3 * 5 + 2) begin bad++; $display("FAIL stall_cycles got=%0d want=%0d", c, 3 * 5 + 2); end
  endtask

  task automatic test_zero_words();
    int c;
    fill_stream();
    do_load(0, 0, -1, -1, c);
    total++; if (c != 1) begin bad++; $display("FAIL zero_done_delay got=%0d want=1", c); end
    total++; if (hold_cnt != 1) begin bad++; $display("FAIL zero_hold_cycles got=%0d want=1", hold_cnt); end
  endtask

  task automatic test_overflow();
    int c;
    fill_stream();
    do_load(40, 25, -1, -1, c);
  endtask

  task automatic test_reset_mid_load();
    int sent, c;
    fill_stream();
    num_words = 6'd2; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    clear_mon();
    sent = 0; c = 0; byte_valid = 1'b1;
    while (sent < 6 && c < 100) begin
      byte_in = stream[sent];
      if (byte_ready) sent++;
      @(posedge clock); #1; c++;
    end
    byte_valid = 1'b0; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL midreset_ready got=%b want=0", byte_ready); end
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL midreset_hold got=%b want=0", cpu_hold); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b want=0", done); end
    total++; if (mem_write_address !== 5'd0) begin bad++; $display("FAIL midreset_addr got=%0d want=0", mem_write_address); end
    total++; if (mem_write_data !== 32'h0) begin bad++; $display("FAIL midreset_data got=%h want=0", mem_write_data); end
    repeat (3) @(posedge clock);
    #1;
    total++; if (wr_addr_q.size() != 1) begin bad++; $display("FAIL midreset_writes got=%0d want=1", wr_addr_q.size()); end
    fill_stream();
    do_load(1, 0, -1, -1, c);
  endtask

  task automatic test_start_ignored();
    int c;
    fill_stream();
    do_load(5, 20, -1, 6, c);
    fill_stream();
    do_load(2, 0, -1, -1, c);
  endtask

  task automatic test_random();
    int c;
    for (int r = 0; r < 6; r++) begin
      fill_stream();
      do_load($urandom_range(40, 0), $urandom_range(60, 0), -1, -1, c);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stall();
    test_zero_words();
    test_overflow();
    test_reset_mid_load();
    test_start_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
